// File: rtl/concat_read_ctrl_pkg.sv
// concat_pkg: shared FSM encoding and burst-select constants
// for the concat-branch read sequencer.
package concat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT0 = 3'd1,
    ST_READ0 = 3'd2,
    ST_WAIT1 = 3'd3,
    ST_READ1 = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic SEL_BR0 = 1'b0;
  localparam logic SEL_BR1 = 1'b1;

endpackage

// File: rtl/concat_read_ctrl_if.sv
// concat_read_ctrl_if: branch FIFO read ports + output stream.
// master = controller side, slave = FIFOs / downstream side.
interface concat_read_ctrl_if #(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 10
) ();

  logic [ADDR_BITS:0] fifo0_m_count;
  logic               fifo0_ready;
  logic               fifo0_rd_en;
  logic [WIDTH-1:0]   fifo0_dout;

  logic [ADDR_BITS:0] fifo1_m_count;
  logic               fifo1_ready;
  logic               fifo1_rd_en;
  logic [WIDTH-1:0]   fifo1_dout;

  logic               out_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output fifo0_m_count,
    input  fifo0_ready,
    output fifo0_rd_en,
    input  fifo0_dout,
    output fifo1_m_count,
    input  fifo1_ready,
    output fifo1_rd_en,
    input  fifo1_dout,
    input  out_ready,
    output out_valid,
    output out_data
  );

  modport slave (
    input  fifo0_m_count,
    output fifo0_ready,
    input  fifo0_rd_en,
    output fifo0_dout,
    input  fifo1_m_count,
    output fifo1_ready,
    input  fifo1_rd_en,
    output fifo1_dout,
    output out_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/concat_read_ctrl_counter.sv
// concat_beat_counter: loadable down-counter, last=1 when one left.
// Ports: clk, rst, load, load_val, dec, last.
module concat_beat_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign last = (cnt == ONE);

endmodule

// File: rtl/concat_read_ctrl.sv
// concat_read_ctrl: interleaves ch0/ch1 FIFO bursts per pixel
// into one stream. Ports: clk, rst, start, ch0_beats, ch1_beats,
// pixel_total, io (FIFO + output bus), busy, done, and
// stall_cycles when CONCAT_READ_PERF_EN is defined.
module concat_read_ctrl
  import concat_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 10,
  parameter int PIX_BITS  = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BITS:0]  ch0_beats,
  input  logic [ADDR_BITS:0]  ch1_beats,
  input  logic [PIX_BITS-1:0] pixel_total,
  concat_read_ctrl_if.master  io,
  output logic                busy,
  output logic                done
`ifdef CONCAT_READ_PERF_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  state_t state;
  state_t state_n;

  logic [ADDR_BITS:0] c0_q;
  logic [ADDR_BITS:0] c1_q;
  logic [ADDR_BITS:0] beat_val;

  logic rd0;
  logic rd1;
  logic latch;
  logic beat_load;
  logic beat_dec;
  logic beat_last;
  logic pix_load;
  logic pix_end;
  logic pix_last;
  logic valid_q;
  logic sel_q;

  concat_beat_counter #(
    .W (ADDR_BITS + 1)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .load     (beat_load),
    .load_val (beat_val),
    .dec      (beat_dec),
    .last     (beat_last)
  );

  concat_beat_counter #(
    .W (PIX_BITS)
  ) u_pix (
    .clk      (clk),
    .rst      (rst),
    .load     (pix_load),
    .load_val (pixel_total),
    .dec      (pix_end),
    .last     (pix_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c0_q <= '0;
      c1_q <= '0;
    end else if (latch) begin
      c0_q <= ch0_beats;
      c1_q <= ch1_beats;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sel_q   <= SEL_BR0;
    end else begin
      valid_q <= rd0 | rd1;
      sel_q   <= rd1 ? SEL_BR1 : SEL_BR0;
    end
  end

  always_comb begin
    state_n   = state;
    rd0       = 1'b0;
    rd1       = 1'b0;
    latch     = 1'b0;
    beat_load = 1'b0;
    beat_val  = c0_q;
    beat_dec  = 1'b0;
    pix_load  = 1'b0;
    pix_end   = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          latch    = 1'b1;
          pix_load = 1'b1;
          if (pixel_total == '0 ||
              (ch0_beats == '0 && ch1_beats == '0)) begin
            state_n = ST_DONE;
          end else if (ch0_beats == '0) begin
            state_n = ST_WAIT1;
          end else begin
            state_n = ST_WAIT0;
          end
        end
      end
      ST_WAIT0: begin
        if (io.fifo0_ready && io.out_ready) begin
          beat_load = 1'b1;
          beat_val  = c0_q;
          state_n   = ST_READ0;
        end
      end
      ST_READ0: begin
        rd0      = 1'b1;
        beat_dec = 1'b1;
        if (beat_last) begin
          if (c1_q == '0) begin
            pix_end = 1'b1;
          end else begin
            state_n = ST_WAIT1;
          end
        end
      end
      ST_WAIT1: begin
        if (io.fifo1_ready && io.out_ready) begin
          beat_load = 1'b1;
          beat_val  = c1_q;
          state_n   = ST_READ1;
        end
      end
      ST_READ1: begin
        rd1      = 1'b1;
        beat_dec = 1'b1;
        if (beat_last) begin
          pix_end = 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // last beat of the last burst in a pixel
    if (pix_end) begin
      if (pix_last) begin
        state_n = ST_DONE;
      end else if (c0_q == '0) begin
        state_n = ST_WAIT1;
      end else begin
        state_n = ST_WAIT0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

  // reset drops read strobes and valid in the same cycle
  assign io.fifo0_rd_en   = rd0 & ~rst;
  assign io.fifo1_rd_en   = rd1 & ~rst;
  assign io.out_valid     = valid_q & ~rst;
  assign io.fifo0_m_count = c0_q;
  assign io.fifo1_m_count = c1_q;

  always_comb begin
    io.out_data = '0;
    if (valid_q) begin
      io.out_data = (sel_q == SEL_BR1) ? io.fifo1_dout
                                       : io.fifo0_dout;
    end
  end

`ifdef CONCAT_READ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cycles <= '0;
    end else if ((state == ST_WAIT0 || state == ST_WAIT1) &&
                 stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_concat_read_ctrl.sv
// tb_concat_read_ctrl: randomized self-checking bench with FIFO
// models and a per-pixel interleave reference stream.
module tb_concat_read_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         clr;
  logic [10:0]  ch0_beats;
  logic [10:0]  ch1_beats;
  logic [19:0]  pixel_total;
  logic         busy;
  logic         done;
`ifdef CONCAT_READ_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  concat_read_ctrl_if #(.WIDTH(128), .ADDR_BITS(10)) bus ();

  concat_read_ctrl #(
    .WIDTH     (128),
    .ADDR_BITS (10),
    .PIX_BITS  (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ch0_beats    (ch0_beats),
    .ch1_beats    (ch1_beats),
    .pixel_total  (pixel_total),
    .io           (bus),
    .busy         (busy),
    .done         (done)
`ifdef CONCAT_READ_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] cnt0;
  logic [31:0] cnt1;

  // FIFO models: dout valid one cycle after rd_en
  always @(posedge clk) begin
    if (clr) begin
      cnt0 <= 0;
      cnt1 <= 0;
    end else begin
      if (bus.fifo0_rd_en) begin
        bus.fifo0_dout <= {64'h0, 32'h0000_00B0, cnt0};
        cnt0 <= cnt0 + 1;
      end
      if (bus.fifo1_rd_en) begin
        bus.fifo1_dout <= {64'h0, 32'h0000_00B1, cnt1};
        cnt1 <= cnt1 + 1;
      end
    end
  end

  logic [127:0] got[$];
  logic [127:0] exp_q[$];
  int n0, n1, both_rd, busy_cnt;
  int done_seen, done_valid, done_cyc;
  int hold_left, hold_bad;
  logic post_busy;

  // reference: per pixel, c0 words of branch 0 then c1 of branch 1
  task automatic build_exp(input int c0, input int c1,
                           input int px);
    int i0 = 0;
    int i1 = 0;
    exp_q.delete();
    for (int p = 0; p < px; p++) begin
      for (int k = 0; k < c0; k++) begin
        exp_q.push_back({64'h0, 32'h0000_00B0, 32'(i0)});
        i0++;
      end
      for (int k = 0; k < c1; k++) begin
        exp_q.push_back({64'h0, 32'h0000_00B1, 32'(i1)});
        i1++;
      end
    end
  endtask

  function automatic int stream_errs();
    int e = 0;
    if (got.size() != exp_q.size()) e++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic logic rnd(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // entry/exit: #1 after a posedge
  task automatic run_job(input int c0, input int c1,
                         input int px, input int pct,
                         input int restart_at,
                         input bit hold_mode);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    got.delete();
    n0 = 0; n1 = 0; both_rd = 0; busy_cnt = 0;
    done_seen = 0; done_valid = 0; done_cyc = -1;
    hold_left = 10; hold_bad = 0;
    ch0_beats   = 11'(c0);
    ch1_beats   = 11'(c1);
    pixel_total = 20'(px);
    start = 1'b1;
    for (int cyc = 0; cyc < 3000 && done_seen == 0; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == restart_at);
      if (start) ch0_beats = 11'd7;
      bus.fifo0_ready = rnd(pct);
      bus.out_ready   = rnd(pct);
      bus.fifo1_ready = rnd(pct);
      if (hold_mode && (n0 < c0 || hold_left > 0))
        bus.fifo1_ready = 1'b0;
      @(negedge clk);
      if (bus.out_valid) got.push_back(bus.out_data);
      if (bus.fifo0_rd_en) n0++;
      if (bus.fifo1_rd_en) n1++;
      if (bus.fifo0_rd_en && bus.fifo1_rd_en) both_rd++;
      if (busy) busy_cnt++;
      if (hold_mode && n0 >= c0 && hold_left > 0) begin
        if (bus.fifo1_rd_en) hold_bad++;
        hold_left--;
      end
      if (done) begin
        done_seen  = 1;
        done_valid = int'(bus.out_valid);
        done_cyc   = cyc;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    post_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clr = 1'b1;
    ch0_beats = '0; ch1_beats = '0; pixel_total = '0;
    bus.fifo0_ready = 1'b0; bus.fifo1_ready = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo0_dout = '0; bus.fifo1_dout = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, bus.out_valid, bus.fifo0_rd_en,
         bus.fifo1_rd_en} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b exp 00000",
        {busy, done, bus.out_valid, bus.fifo0_rd_en,
         bus.fifo1_rd_en});
    end
    total++;
    if ({bus.fifo0_m_count, bus.fifo1_m_count} !== 22'd0) begin
      bad++;
      $display("FAIL reset_mcount: got %0d/%0d exp 0/0",
        bus.fifo0_m_count, bus.fifo1_m_count);
    end
    total++;
    if (bus.out_data !== 128'd0) begin
      bad++;
      $display("FAIL reset_data: got %h exp 0", bus.out_data);
    end
`ifdef CONCAT_READ_PERF_EN
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_stall: got %0d exp 0", stall_cycles);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    build_exp(4, 2, 3);
    run_job(4, 2, 3, 100, -1, 1'b0);
    total++;
    if (stream_errs() !== 0) begin
      bad++;
      $display("FAIL basic_stream: got %0d words errs %0d exp %0d",
        got.size(), stream_errs(), exp_q.size());
    end
    total++;
    if (done_seen !== 1 || done_valid !== 1) begin
      bad++;
      $display("FAIL basic_done: got seen=%0d valid=%0d exp 1/1",
        done_seen, done_valid);
    end
    total++;
    if ({bus.fifo0_m_count, bus.fifo1_m_count} !==
        {11'd4, 11'd2}) begin
      bad++;
      $display("FAIL basic_mcount: got %0d/%0d exp 4/2",
        bus.fifo0_m_count, bus.fifo1_m_count);
    end
    total++;
    if (post_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: got busy=%b exp 0", post_busy);
    end
`ifdef CONCAT_READ_PERF_EN
    total++;
    if (stall_cycles !== 32'd6) begin
      bad++;
      $display("FAIL basic_stall: got %0d exp 6", stall_cycles);
    end
`endif
  endtask

  task automatic test_wait1_stall();
    build_exp(4, 2, 1);
    run_job(4, 2, 1, 100, -1, 1'b1);
    total++;
    if (hold_bad !== 0 || hold_left !== 0) begin
      bad++;
      $display("FAIL stall_hold: got rd1=%0d left=%0d exp 0/0",
        hold_bad, hold_left);
    end
    total++;
    if (stream_errs() !== 0) begin
      bad++;
      $display("FAIL stall_stream: got %0d words exp %0d",
        got.size(), exp_q.size());
    end
`ifdef CONCAT_READ_PERF_EN
    total++;
    if (stall_cycles < 32'd10) begin
      bad++;
      $display("FAIL stall_perf: got %0d exp >=10", stall_cycles);
    end
`endif
  endtask

  task automatic test_ch0_zero();
    build_exp(0, 3, 2);
    run_job(0, 3, 2, 70, -1, 1'b0);
    total++;
    if (n0 !== 0) begin
      bad++;
      $display("FAIL ch0z_rd0: got %0d exp 0", n0);
    end
    total++;
    if (stream_errs() !== 0 || got.size() !== 6) begin
      bad++;
      $display("FAIL ch0z_stream: got %0d words exp 6",
        got.size());
    end
  endtask

  task automatic test_empty();
    build_exp(3, 2, 0);
    run_job(3, 2, 0, 100, -1, 1'b0);
    total++;
    if (done_cyc !== 0 || n0 + n1 !== 0) begin
      bad++;
      $display("FAIL empty_px: got cyc=%0d rd=%0d exp 0/0",
        done_cyc, n0 + n1);
    end
    total++;
    if (busy_cnt !== 1 || got.size() !== 0) begin
      bad++;
      $display("FAIL empty_busy: got busy=%0d words=%0d exp 1/0",
        busy_cnt, got.size());
    end
    run_job(0, 0, 5, 100, -1, 1'b0);
    total++;
    if (done_cyc !== 0 || n0 + n1 !== 0) begin
      bad++;
      $display("FAIL empty_beats: got cyc=%0d rd=%0d exp 0/0",
        done_cyc, n0 + n1);
    end
  endtask

  task automatic test_restart();
    build_exp(3, 2, 2);
    run_job(3, 2, 2, 100, 4, 1'b0);
    total++;
    if (bus.fifo0_m_count !== 11'd3) begin
      bad++;
      $display("FAIL restart_mcount: got %0d exp 3",
        bus.fifo0_m_count);
    end
    total++;
    if (stream_errs() !== 0 || done_seen !== 1) begin
      bad++;
      $display("FAIL restart_stream: got %0d words exp %0d",
        got.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus.fifo0_ready = 1'b1; bus.fifo1_ready = 1'b1;
    bus.out_ready = 1'b1;
    ch0_beats = 11'd4; ch1_beats = 11'd1;
    pixel_total = 20'd2;
    start = 1'b1;
    for (int cyc = 0; cyc < 50 && k < 3; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (bus.fifo0_rd_en) k++;
    end
    total++;
    if (k !== 3) begin
      bad++;
      $display("FAIL rstmid_reach: got beats=%0d exp 3", k);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.fifo0_rd_en, bus.out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_same: got %b exp 00",
        {bus.fifo0_rd_en, bus.out_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.fifo0_rd_en, bus.fifo1_rd_en, bus.out_valid,
         busy} !== 4'b0) begin
      bad++;
      $display("FAIL rstmid_next: got %b exp 0000",
        {bus.fifo0_rd_en, bus.fifo1_rd_en, bus.out_valid, busy});
    end
    @(posedge clk); #1;
    build_exp(4, 2, 2);
    run_job(4, 2, 2, 100, -1, 1'b0);
    total++;
    if (stream_errs() !== 0 || done_valid !== 1) begin
      bad++;
      $display("FAIL rstmid_rerun: got %0d words exp %0d",
        got.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int c0 = int'($urandom_range(5));
      int c1 = int'($urandom_range(5));
      int px = int'($urandom_range(4));
      build_exp(c0, c1, px);
      run_job(c0, c1, px, 60, -1, 1'b0);
      total++;
      if (stream_errs() !== 0 || done_seen !== 1) begin
        bad++;
        $display("FAIL rand_stream[%0d] %0d/%0d/%0d: got %0d exp %0d",
          j, c0, c1, px, got.size(), exp_q.size());
      end
      total++;
      if (n0 !== c0 * px || n1 !== c1 * px || both_rd !== 0) begin
        bad++;
        $display("FAIL rand_rd[%0d]: got %0d/%0d/%0d exp %0d/%0d/0",
          j, n0, n1, both_rd, c0 * px, c1 * px);
      end
      total++;
      if (exp_q.size() > 0 && done_valid !== 1) begin
        bad++;
        $display("FAIL rand_done[%0d]: got valid=%0d exp 1",
          j, done_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait1_stall();
    test_ch0_zero();
    test_empty();
    test_restart();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/concat_read_ctrl.md
Name: concat_read_ctrl

Overview:
- Sequences the two concat-branch read FIFOs so that per-pixel channel data is interleaved into one output stream: ch0_beats words from branch 0, then ch1_beats words from branch 1, for each of pixel_total pixels.
- Sits between the two branch FIFOs (through their M_count/M_Ready interface) and the downstream write stage (through its S_Ready space indicator).
- Owns both fifo rd_en lines and the output data mux.

Parameters:
- WIDTH, 128, data word width of both FIFOs and the output
- ADDR_BITS, 10, FIFO depth exponent; beat counts are ADDR_BITS+1 bits wide
- PIX_BITS, 20, width of the pixel counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches the configuration and begins the job
- ch0_beats  in  ADDR_BITS+1  words per pixel from branch 0
- ch1_beats  in  ADDR_BITS+1  words per pixel from branch 1
- pixel_total  in  PIX_BITS  pixels in the job
- fifo0_m_count  out  ADDR_BITS+1  latched ch0_beats, driven to the branch-0 FIFO M_count
- fifo0_ready  in  1  branch-0 FIFO M_Ready (data_count >= M_count)
- fifo0_rd_en  out  1  branch-0 read enable
- fifo0_dout  in  WIDTH  branch-0 data, valid one cycle after rd_en
- fifo1_m_count, fifo1_ready, fifo1_rd_en, fifo1_dout  same roles for branch 1
- out_ready  in  1  downstream S_Ready (space available)
- out_valid  out  1  output word valid
- out_data  out  WIDTH  output word
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0, m_counts 0, FSM in IDLE.
- FSM states: IDLE, WAIT0, READ0, WAIT1, READ1, DONE.
- IDLE, on start: latch ch0_beats, ch1_beats, pixel_total; pix_cnt=0.
  - pixel_total==0, or both beat counts 0: go to DONE.
  - ch0_beats==0: go to WAIT1.
  - otherwise: go to WAIT0.
  - busy=1 in every state except IDLE.
- WAIT0 -> READ0 when fifo0_ready && out_ready are sampled high in the same cycle. The whole burst is guaranteed resident, so READ0 never stalls.
- READ0: fifo0_rd_en=1 every cycle; beat_cnt counts 0..ch0_beats-1. On the last beat, go to WAIT1, or skip to the pixel-end step if ch1_beats==0.
- WAIT1/READ1: identical handshake and read pattern on branch 1 using ch1_beats.
- Pixel-end step (combinational in the last-beat cycle): pix_cnt+1.
  - If it equals pixel_total, go to DONE.
  - Otherwise go to WAIT0, or to WAIT1 if ch0_beats==0.
- out_valid = rd_en (either branch) delayed one cycle. out_data = registered select ? fifo1_dout : fifo0_dout.
- Latency from rd_en to out_valid: 1 cycle.
- Back-to-back bursts are allowed; min 1 WAIT cycle between bursts.
- DONE lasts one cycle: done=1, busy=1, then IDLE. done coincides with the final out_valid. For an empty job, done occurs 1 cycle after start.
- start while busy: ignored, latched config unchanged.
- out_ready is sampled only at burst start. Downstream guarantees margin >= max(ch0_beats, ch1_beats).
- rst mid-job: immediate return to IDLE; rd_en and out_valid drop in the same cycle; counters cleared.
- fifo_m_count holds its latched value until the next start.

Optional Feature:
- Macro CONCAT_READ_PERF_EN.
- Defined: adds output stall_cycles (32 bits).
  - Cleared on start and on rst.
  - Increments every cycle the FSM is in WAIT0 or WAIT1; saturates at 0xFFFFFFFF.
  - Holds its value after done.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package concat_pkg holds:
  - FSM state encoding typedef (3 bits)
  - ST_* constants
  - burst-select constants SEL_BR0=0, SEL_BR1=1
- One natural sub-module: concat_beat_counter, a loadable down-counter with terminal flag. Instantiated once for beats and once for pixels.

Test Plan:
- ch0=4, ch1=2, pixels=3, both ready and out_ready held high -> 18 out_valid words; order: 4×fifo0, 2×fifo1, repeated ×3; done pulses with the 18th word.
- fifo1_ready low for 10 cycles after the branch-0 burst -> controller holds WAIT1, no rd_en. With the PERF macro, stall_cycles >= 10.
- ch0=0, ch1=3, pixels=2 -> fifo0_rd_en never asserts; 6 words from fifo1.
- pixel_total=0 at start -> no rd_en; done exactly 1 cycle after start; busy high for 1 cycle.
- start re-pulsed mid-job with ch0=7 -> ignored; fifo0_m_count keeps the original value; job finishes with the original counts.
- rst asserted during READ0 beat 2 of 4 -> next cycle: rd_en=0, out_valid=0, busy=0; a fresh start runs a full job correctly.
